// File: rtl/uart_pkg.sv
// Shared UART constants, FSM state encodings and baud divisor helper.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;
    localparam int unsigned UART_GAP_BITS  = 20;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE     = 4'd0;
    localparam state_t ST_RX_START = 4'd1;
    localparam state_t ST_RX_DATA  = 4'd2;
    localparam state_t ST_RX_STOP  = 4'd3;
    localparam state_t ST_RX_GAP   = 4'd4;
    localparam state_t ST_TX_START = 4'd5;
    localparam state_t ST_TX_DATA  = 4'd6;
    localparam state_t ST_TX_STOP  = 4'd7;
    localparam state_t ST_ERR_WAIT = 4'd8;

    function automatic int unsigned baud_div(input int unsigned clk, input int unsigned baud);
        return clk / baud;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter with clear; flags the half-bit and last cycle of each bit period.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 434
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic tick_half_c_o,
    output logic tick_full_c_o
);

    localparam int unsigned      CNT_W     = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BAUD_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick_half_c_o = (cnt_q == HALF_LAST);
    assign tick_full_c_o = (cnt_q == FULL_LAST);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr_i || tick_full_c_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_frame_rsp.sv
// UART frame responder: receives MulNum-byte 8N1 requests and echoes them
// back followed by an XOR checksum over a half-duplex link.
module uart_frame_rsp
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 115_200,
    parameter int unsigned MulNum   = 3
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic                  uartrx,
    output logic                  uarttx,
    output logic [8*MulNum-1:0]   req_dats,
    output logic                  req_valid,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int unsigned BAUD_DIV = baud_div(CLK_FREQ, BAUD);
    localparam int unsigned DW       = UART_DATA_BITS;
    localparam int unsigned FW       = DW * MulNum;
    localparam int unsigned IDX_W    = 4;
    localparam int unsigned GAP_LIM  = UART_GAP_BITS * BAUD_DIV;
    localparam int unsigned GAP_W    = $clog2(GAP_LIM + 1);

    localparam logic [2:0]       LAST_BIT  = 3'(DW - 1);
    localparam logic [IDX_W-1:0] LAST_RX   = IDX_W'(MulNum - 1);
    localparam logic [IDX_W-1:0] LAST_TX   = IDX_W'(MulNum);
    localparam logic [GAP_W-1:0] GAP_END   = GAP_W'(GAP_LIM - 1);
    localparam logic [GAP_W-1:0] QUIET_END = GAP_W'(BAUD_DIV - 1);

    state_t            state_q, state_d;
    logic              rx_s1_q, rx_s2_q, rx_prev_q;
    logic [2:0]        bit_q, bit_d;
    logic [IDX_W-1:0]  byte_q, byte_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [DW-1:0]     rx_sr_q, rx_sr_d;
    logic [DW-1:0]     tx_sr_q, tx_sr_d;
    logic [FW-1:0]     frame_q, frame_d;
    logic [DW-1:0]     csum_q, csum_d;
    logic              uarttx_q, uarttx_d;
    logic [FW-1:0]     req_dats_q, req_dats_d;
    logic              req_valid_q, req_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              busy_q, busy_d;

    logic              rx_fall_c;
    logic              baud_clr_c;
    logic              tick_half_c, tick_full_c;
    logic [FW-1:0]     frame_nx_c;
    logic [IDX_W-1:0]  byte_inc_c;
    logic [DW-1:0]     nxt_byte_c;

    uart_baud_tick #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud (
        .clk_i         (sys_clk),
        .rst_i         (rst),
        .clr_i         (baud_clr_c),
        .tick_half_c_o (tick_half_c),
        .tick_full_c_o (tick_full_c)
    );

    assign rx_fall_c  = rx_prev_q & ~rx_s2_q;
    assign frame_nx_c = (frame_q << DW) | FW'(rx_sr_q);
    assign byte_inc_c = byte_q + IDX_W'(1);

    // Next reply byte: request bytes in arrival order, checksum last.
    always_comb begin
        nxt_byte_c = csum_q;
        for (int k = 0; k < int'(MulNum); k++) begin
            if (byte_inc_c == IDX_W'(k)) begin
                nxt_byte_c = frame_q[FW-DW-DW*k +: DW];
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_prev_q   <= 1'b1;
            bit_q       <= '0;
            byte_q      <= '0;
            gap_q       <= '0;
            rx_sr_q     <= '0;
            tx_sr_q     <= '0;
            frame_q     <= '0;
            csum_q      <= '0;
            uarttx_q    <= 1'b1;
            req_dats_q  <= '0;
            req_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_s1_q     <= uartrx;
            rx_s2_q     <= rx_s1_q;
            rx_prev_q   <= rx_s2_q;
            bit_q       <= bit_d;
            byte_q      <= byte_d;
            gap_q       <= gap_d;
            rx_sr_q     <= rx_sr_d;
            tx_sr_q     <= tx_sr_d;
            frame_q     <= frame_d;
            csum_q      <= csum_d;
            uarttx_q    <= uarttx_d;
            req_dats_q  <= req_dats_d;
            req_valid_q <= req_valid_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_d      = bit_q;
        byte_d     = byte_q;
        gap_d      = gap_q;
        rx_sr_d    = rx_sr_q;
        tx_sr_d    = tx_sr_q;
        frame_d    = frame_q;
        csum_d     = csum_q;
        baud_clr_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                byte_d = '0;
                gap_d  = '0;
                if (rx_fall_c) begin
                    state_d    = ST_RX_START;
                    baud_clr_c = 1'b1;
                end
            end
            ST_RX_START: begin
                if (tick_half_c) begin
                    if (!rx_s2_q) begin
                        state_d    = ST_RX_DATA;
                        baud_clr_c = 1'b1;
                        bit_d      = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RX_DATA: begin
                if (tick_full_c) begin
                    rx_sr_d = {rx_s2_q, rx_sr_q[DW-1:1]};
                    bit_d   = bit_q + 3'(1);
                    if (bit_q == LAST_BIT) begin
                        state_d = ST_RX_STOP;
                    end
                end
            end
            ST_RX_STOP: begin
                if (tick_full_c) begin
                    gap_d = '0;
                    if (!rx_s2_q) begin
                        state_d = ST_ERR_WAIT;
                        byte_d  = '0;
                    end else begin
                        frame_d = frame_nx_c;
                        csum_d  = ((byte_q == '0) ? '0 : csum_q) ^ rx_sr_q;
                        if (byte_q == LAST_RX) begin
                            state_d    = ST_TX_START;
                            baud_clr_c = 1'b1;
                            byte_d     = '0;
                            bit_d      = '0;
                            tx_sr_d    = frame_nx_c[FW-1 -: DW];
                        end else begin
                            state_d = ST_RX_GAP;
                            byte_d  = byte_inc_c;
                        end
                    end
                end
            end
            ST_RX_GAP: begin
                // Timeout is checked first so a coincident start edge is dropped.
                if (gap_q == GAP_END) begin
                    state_d = ST_IDLE;
                    byte_d  = '0;
                end else if (rx_fall_c) begin
                    state_d    = ST_RX_START;
                    baud_clr_c = 1'b1;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            ST_TX_START: begin
                if (tick_full_c) begin
                    state_d = ST_TX_DATA;
                end
            end
            ST_TX_DATA: begin
                if (tick_full_c) begin
                    tx_sr_d = {1'b0, tx_sr_q[DW-1:1]};
                    bit_d   = bit_q + 3'(1);
                    if (bit_q == LAST_BIT) begin
                        state_d = ST_TX_STOP;
                    end
                end
            end
            ST_TX_STOP: begin
                if (tick_full_c) begin
                    if (byte_q == LAST_TX) begin
                        state_d = ST_IDLE;
                        byte_d  = '0;
                    end else begin
                        state_d = ST_TX_START;
                        byte_d  = byte_inc_c;
                        tx_sr_d = nxt_byte_c;
                    end
                end
            end
            ST_ERR_WAIT: begin
                if (!rx_s2_q) begin
                    gap_d = '0;
                end else if (gap_q == QUIET_END) begin
                    state_d = ST_IDLE;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the upcoming state so the line changes with the state.
    always_comb begin
        uarttx_d = 1'b1;
        if (state_d == ST_TX_START) begin
            uarttx_d = 1'b0;
        end else if (state_d == ST_TX_DATA) begin
            uarttx_d = tx_sr_d[0];
        end
        busy_d      = (state_d != ST_IDLE);
        req_valid_d = (state_q == ST_RX_STOP) && (state_d == ST_TX_START);
        frame_err_d = ((state_q == ST_RX_STOP) && (state_d == ST_ERR_WAIT)) ||
                      ((state_q == ST_RX_GAP)  && (state_d == ST_IDLE));
        req_dats_d  = req_valid_d ? frame_nx_c : req_dats_q;
    end

    assign uarttx    = uarttx_q;
    assign req_dats  = req_dats_q;
    assign req_valid = req_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule
